fb_rect_writer: RTL and testbench
=================================

Name: fb_rect_writer

Overview:
- Write-side companion to the VGA display path: fills axis-aligned rectangles of one palette index into the image frame-buffer RAM, which the display path reads as x + 640*y.
- Accepts one rectangle command per valid/ready handshake and emits one RAM write per clock in raster order.
- Intended use: redrawing paddles and ball during vertical blanking, launched from game logic on screenEnd.

Parameters:
- WIDTH, 640, visible pixels per row; also the address stride.
- HEIGHT, 480, visible rows.
- ADDR_W, 20, frame-buffer address width; equals $clog2(WIDTH*HEIGHT)+1.
- DATA_W, 9, palette-index width; equals $clog2(256)+1.

Ports:
- clk  in  1  system clock (100 MHz); all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  rectangle command present.
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
- cmd_x  in  10  left column of rectangle.
- cmd_y  in  9  top row of rectangle.
- cmd_w  in  10  width in pixels.
- cmd_h  in  9  height in pixels.
- cmd_color  in  DATA_W  palette index to write.
- abort  in  1  cancels the command in progress.
- busy  out  1  high in DRAW.
- done  out  1  one-cycle pulse when a command completes.
- wEn  out  1  frame-buffer write enable.
- addr  out  ADDR_W  frame-buffer write address.
- dataIn  out  DATA_W  frame-buffer write data.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: state IDLE, cmd_ready=1, busy=0, done=0, wEn=0, addr=0, dataIn=0. Reset mid-DRAW drops wEn at the same edge, and no done is issued.
- All outputs are registered.
- States:
  - IDLE: wait for accept.
  - DRAW: issue writes.
  - DONE: one cycle, done=1, cmd_ready=0, then return to IDLE.
- On accept, the command is latched and clipped:
  - w_eff = min(cmd_w, WIDTH-cmd_x)
  - h_eff = min(cmd_h, HEIGHT-cmd_y)
  - Empty command: cmd_x>=WIDTH, cmd_y>=HEIGHT, w_eff==0 or h_eff==0. Go to DONE with zero writes, so done is high the cycle after accept.
  - Otherwise go to DRAW.
- DRAW write sequence:
  - The first write (wEn=1) appears the cycle after accept.
  - Writes are row-major and one per cycle, with no bubbles: exactly w_eff*h_eff consecutive cycles.
  - addr = row_base + cmd_x + col, where row_base starts at cmd_y*WIDTH and adds WIDTH at each row wrap.
  - No multiplier is allowed beyond the constant multiply at accept.
  - dataIn = latched color for the whole command.
- After the last write, wEn=0 and done=1 together in the next cycle (DONE state).
- abort in DRAW: next cycle wEn=0 and state is IDLE; no done pulse. abort in IDLE or DONE is ignored.
- Simultaneous abort and last write: abort wins, so no done.
- cmd_valid is ignored outside IDLE; commands are not queued.
- Arithmetic: column counter is 10 bits, row counter 9 bits, address sum ADDR_W bits. Clipping guarantees the address stays below WIDTH*HEIGHT (max 307199).

Optional Feature:
- Macro: FB_RECT_WRITER_OUTLINE_EN.
- When defined:
  - Adds input cmd_outline (1 bit), latched on accept.
  - If set, only pixels with col==0, col==w_eff-1, row==0 or row==h_eff-1 are written. Interior positions still take one cycle each with wEn=0, so the command still lasts w_eff*h_eff cycles.
  - Outline edges follow the clipped rectangle.
- When undefined: the port is absent and every pixel is written.

Decomposition:
- Shared package fb_pkg holds:
  - WIDTH, HEIGHT, ADDR_W, DATA_W constants.
  - State enum {IDLE, DRAW, DONE}.
  - Coordinate/size typedefs: x_t [9:0], y_t [8:0].
  - The display path and game logic reuse fb_pkg.
- One natural sub-module, fb_raster_counter:
  - Column/row counters with load, advance, clear.
  - Flags col_last, row_last, first/last-edge (used by the outline option).
  - Row-base accumulator.

Test Plan:
- Idle after reset: assert reset 2 cycles, then idle 10 cycles -> wEn=0, cmd_ready=1, busy=0, done never asserted.
- Basic fill: x=10, y=2, w=3, h=2, color=5 -> 6 consecutive writes starting the cycle after accept:
  - addr 1290, 1291, 1292, 1930, 1931, 1932; dataIn=5.
  - done high the cycle after addr 1932; cmd_ready returns the cycle after done.
- Clipping: x=638, y=479, w=5, h=4, color=7 -> exactly 2 writes (addr 307198, 307199), then done; no address >=307200 ever.
- Empty: w=0 (or x=700) -> zero writes; done the cycle after accept.
- Abort: x=0, y=0, w=4, h=1, with abort held during the 3rd write (addr 2) -> wEn=0 next cycle, no done, cmd_ready=1; a new command is accepted immediately.
- Outline (macro defined): x=0, y=0, w=3, h=3, cmd_outline=1 -> 9 command cycles, 8 writes, addr 641 never written; done after cycle 9.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: screen geometry, bus widths, the rectangle
// writer state encoding and coordinate types. Reused by display path and game logic.
package fb_pkg;

    localparam int WIDTH  = 640;                        // visible pixels per row, also address stride
    localparam int HEIGHT = 480;                        // visible rows
    localparam int ADDR_W = $clog2(WIDTH*HEIGHT) + 1;   // 20
    localparam int DATA_W = $clog2(256) + 1;            // 9

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    typedef logic [9:0]        x_t;
    typedef logic [8:0]        y_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] color_t;

    // Length of a span starting at pos, clipped to end at limit; zero when pos is off-screen.
    function automatic logic [10:0] clipSpan(input logic [10:0] pos,
                                             input logic [10:0] len,
                                             input logic [10:0] limit);
        logic [10:0] room;
        room = (pos < limit) ? (limit - pos) : 11'd0;
        return (len < room) ? len : room;
    endfunction

endpackage

// File: rtl/fb_raster_counter.sv
// Raster walker for one rectangle: column/row counters plus a row-base address
// accumulator, so no multiplier is needed while drawing. Exposes next-position
// values so the owner can register the write address directly.
// With FB_RECT_WRITER_OUTLINE_EN defined, also flags whether the next position
// lies on the rectangle border.
module fb_raster_counter
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,         // start a new rectangle at (0,0)
    input  logic              advance,      // step one pixel in raster order
    input  logic              clear,        // return to the idle position
    input  logic [ADDR_W-1:0] loadRowBase,  // y*WIDTH of the first row
    input  logic [9:0]        lastCol,      // clipped width - 1
    input  logic [8:0]        lastRow,      // clipped height - 1
    output logic [9:0]        colNext,
    output logic [ADDR_W-1:0] rowBaseNext,
`ifdef FB_RECT_WRITER_OUTLINE_EN
    output logic              nextOnEdge,
`endif
    output logic              colLast,
    output logic              rowLast
);

    x_t    col;
    y_t    row;
    addr_t rowBase;
    y_t    rowNext;

    assign colLast = (col == lastCol);
    assign rowLast = (row == lastRow);

`ifdef FB_RECT_WRITER_OUTLINE_EN
    // Border test on the position about to become current.
    assign nextOnEdge = (colNext == 10'd0) || (colNext == lastCol) ||
                        (rowNext == 9'd0)  || (rowNext == lastRow);
`endif

    // Next position: clear beats load beats advance; row wrap bumps the row base by one stride.
    always_comb begin
        colNext     = col;
        rowNext     = row;
        rowBaseNext = rowBase;
        if (clear) begin
            colNext     = '0;
            rowNext     = '0;
            rowBaseNext = '0;
        end else if (load) begin
            colNext     = '0;
            rowNext     = '0;
            rowBaseNext = loadRowBase;
        end else if (advance) begin
            if (colLast) begin
                colNext     = '0;
                rowNext     = row + 9'd1;
                rowBaseNext = rowBase + addr_t'(WIDTH);
            end else begin
                colNext = col + 10'd1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            col     <= '0;
            row     <= '0;
            rowBase <= '0;
        end else begin
            col     <= colNext;
            row     <= rowNext;
            rowBase <= rowBaseNext;
        end
    end

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle filler for the image frame buffer (address x + WIDTH*y). Takes one
// command per valid/ready handshake, clips it to the screen and issues one
// registered RAM write per clock in raster order.
// Optional: FB_RECT_WRITER_OUTLINE_EN adds cmd_outline (draw border only).
module fb_rect_writer
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [8:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [8:0]        cmd_h,
    input  logic [DATA_W-1:0] cmd_color,
`ifdef FB_RECT_WRITER_OUTLINE_EN
    input  logic              cmd_outline,
`endif
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              wEn,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dataIn
);

    state_t state, stateNext;

    // Latched command, valid while drawing.
    x_t    xLat;
    x_t    lastColLat;
    y_t    lastRowLat;

    // Clipped geometry of the incoming command.
    x_t    wEffNew;
    y_t    hEffNew;
    logic  cmdEmpty;
    addr_t rowBaseNew;

    // Controls and next values of the registered outputs.
    logic  load, advance, clear;
    logic  readyNext, busyNext, doneNext, wEnNext, pixelOn;
    addr_t addrNext;
    color_t dataNext;

    // Counter interface; selects feed the freshly clipped command on the load cycle.
    x_t    lastColSel, xSel, colNext;
    y_t    lastRowSel;
    addr_t rowBaseNext;
    logic  colLast, rowLast;

    assign wEffNew    = x_t'(clipSpan({1'b0, cmd_x}, {1'b0, cmd_w}, 11'(WIDTH)));
    assign hEffNew    = y_t'(clipSpan({2'b0, cmd_y}, {2'b0, cmd_h}, 11'(HEIGHT)));
    assign cmdEmpty   = (wEffNew == '0) || (hEffNew == '0);
    assign rowBaseNew = addr_t'(cmd_y) * addr_t'(WIDTH);

    assign lastColSel = load ? (wEffNew - 10'd1) : lastColLat;
    assign lastRowSel = load ? (hEffNew - 9'd1)  : lastRowLat;
    assign xSel       = load ? cmd_x : xLat;

`ifdef FB_RECT_WRITER_OUTLINE_EN
    logic outlineLat, nextOnEdge;
    // Interior positions of an outline command still take their cycle, just without a write.
    assign pixelOn = (load ? cmd_outline : outlineLat) ? nextOnEdge : 1'b1;
`else
    assign pixelOn = 1'b1;
`endif

    fb_raster_counter uRaster (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .advance     (advance),
        .clear       (clear),
        .loadRowBase (rowBaseNew),
        .lastCol     (lastColSel),
        .lastRow     (lastRowSel),
        .colNext     (colNext),
        .rowBaseNext (rowBaseNext),
`ifdef FB_RECT_WRITER_OUTLINE_EN
        .nextOnEdge  (nextOnEdge),
`endif
        .colLast     (colLast),
        .rowLast     (rowLast)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Next state and next output values; abort takes priority over the final write.
    always_comb begin
        stateNext = state;
        load      = 1'b0;
        advance   = 1'b0;
        clear     = 1'b0;
        readyNext = 1'b0;
        busyNext  = 1'b0;
        doneNext  = 1'b0;
        wEnNext   = 1'b0;
        addrNext  = addr;
        dataNext  = dataIn;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmdEmpty) begin
                        stateNext = DONE;
                        doneNext  = 1'b1;
                    end else begin
                        stateNext = DRAW;
                        load      = 1'b1;
                        busyNext  = 1'b1;
                        wEnNext   = pixelOn;
                        addrNext  = rowBaseNext + addr_t'(xSel) + addr_t'(colNext);
                        dataNext  = cmd_color;
                    end
                end else begin
                    readyNext = 1'b1;
                end
            end
            DRAW: begin
                if (abort) begin
                    stateNext = IDLE;
                    clear     = 1'b1;
                    readyNext = 1'b1;
                end else if (colLast && rowLast) begin
                    stateNext = DONE;
                    clear     = 1'b1;
                    doneNext  = 1'b1;
                end else begin
                    advance   = 1'b1;
                    busyNext  = 1'b1;
                    wEnNext   = pixelOn;
                    addrNext  = rowBaseNext + addr_t'(xSel) + addr_t'(colNext);
                end
            end
            DONE: begin
                stateNext = IDLE;
                readyNext = 1'b1;
            end
            default: begin
                stateNext = IDLE;
                readyNext = 1'b1;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            wEn       <= 1'b0;
            addr      <= '0;
            dataIn    <= '0;
        end else begin
            cmd_ready <= readyNext;
            busy      <= busyNext;
            done      <= doneNext;
            wEn       <= wEnNext;
            addr      <= addrNext;
            dataIn    <= dataNext;
        end
    end

    // Command latch, captured only when a non-empty command is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            xLat       <= '0;
            lastColLat <= '0;
            lastRowLat <= '0;
`ifdef FB_RECT_WRITER_OUTLINE_EN
            outlineLat <= 1'b0;
`endif
        end else if (load) begin
            xLat       <= cmd_x;
            lastColLat <= wEffNew - 10'd1;
            lastRowLat <= hEffNew - 9'd1;
`ifdef FB_RECT_WRITER_OUTLINE_EN
            outlineLat <= cmd_outline;
`endif
        end
    end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Self-checking bench for fb_rect_writer: table of rectangle commands, a
// scoreboard of expected writes, and hand sequences for reset/abort corners.
module tb_fb_rect_writer;
    import fb_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid, cmd_ready;
    logic [9:0]        cmd_x, cmd_w;
    logic [8:0]        cmd_y, cmd_h;
    logic [DATA_W-1:0] cmd_color;
    logic              abort, busy, done, wEn;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dataIn;
`ifdef FB_RECT_WRITER_OUTLINE_EN
    logic              cmd_outline;
`endif

    fb_rect_writer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
`ifdef FB_RECT_WRITER_OUTLINE_EN
        .cmd_outline (cmd_outline),
`endif
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .wEn       (wEn),
        .addr      (addr),
        .dataIn    (dataIn)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int wrSeen     = 0;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;
    wr_t expQ[$];

    typedef struct {
        string name;
        int    x, y, w, h, color;
        bit    outline;
        int    abortAt;     // write index during which abort is held, -1 for none
        bit    holdValid;   // keep cmd_valid high with junk fields while drawing
        int    expWrites;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int span(input int pos, input int len, input int limit);
        int room;
        room = (pos < limit) ? limit - pos : 0;
        return (len < room) ? len : room;
    endfunction

    // Scoreboard: every write must match the head of the expected queue.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (wEn === 1'b1) begin
            wrSeen++;
            if (addr >= ADDR_W'(WIDTH*HEIGHT)) begin
                compared++; mismatched++;
                $display("FAIL addr_range: got %0d expected below %0d", addr, WIDTH*HEIGHT);
            end
            if (expQ.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL unexpected_write: got addr %0d expected no write", addr);
            end else begin
                e = expQ.pop_front();
                chk("wr_addr", addr, e.a);
                chk("wr_data", dataIn, e.d);
            end
        end
    end

    // Runs one command from the table; called and returns just after a negedge.
    task automatic runCmd(input vec_t v);
        int  wE, hE, n, t, idx;
        bit  edgePix, okBusy, sawDone;
        wr_t e;
        wE = span(v.x, v.w, WIDTH);
        hE = span(v.y, v.h, HEIGHT);
        n  = wE * hE;
        for (int r = 0; r < hE; r++) begin
            for (int c = 0; c < wE; c++) begin
                idx     = r * wE + c;
                edgePix = (r == 0) || (r == hE - 1) || (c == 0) || (c == wE - 1);
                if (v.abortAt >= 0 && idx > v.abortAt) continue;
                if (v.outline && !edgePix) continue;
                e.a = ADDR_W'((v.y + r) * WIDTH + v.x + c);
                e.d = DATA_W'(v.color);
                expQ.push_back(e);
            end
        end

        t = 0;
        while (cmd_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({v.name, "_ready_before"}, cmd_ready, 1);

        wrSeen    = 0;
        cmd_valid = 1'b1;
        cmd_x     = 10'(v.x);
        cmd_y     = 9'(v.y);
        cmd_w     = 10'(v.w);
        cmd_h     = 9'(v.h);
        cmd_color = DATA_W'(v.color);
`ifdef FB_RECT_WRITER_OUTLINE_EN
        cmd_outline = v.outline;
`endif
        @(negedge clk);
        if (v.holdValid) begin
            cmd_x = 10'd1; cmd_y = 9'd1; cmd_w = 10'd1; cmd_h = 9'd1; cmd_color = '0;
        end else begin
            cmd_valid = 1'b0;
        end

        if (n == 0) begin
            chk({v.name, "_empty_done"}, done, 1);
            chk({v.name, "_empty_wen"}, wEn, 0);
            @(negedge clk);
            chk({v.name, "_empty_ready"}, cmd_ready, 1);
            chk({v.name, "_empty_done_low"}, done, 0);
        end else begin
            chk({v.name, "_first_wen"}, wEn, 1);
            okBusy  = 1'b1;
            sawDone = 1'b0;
            t = 0;
            forever begin
                okBusy  &= (busy === 1'b1) && (cmd_ready === 1'b0);
                sawDone |= (done === 1'b1);
                if (v.holdValid && t == n - 1) cmd_valid = 1'b0;
                if (t == v.abortAt) abort = 1'b1;
                if (t == n - 1 || t == v.abortAt || t > 2000) break;
                @(negedge clk);
                t++;
            end
            chk({v.name, "_busy_during"}, okBusy, 1);
            chk({v.name, "_no_early_done"}, sawDone, 0);
            @(negedge clk);
            abort = 1'b0;
            if (v.abortAt >= 0) begin
                chk({v.name, "_abort_wen"}, wEn, 0);
                chk({v.name, "_abort_busy"}, busy, 0);
                chk({v.name, "_abort_nodone"}, done, 0);
                chk({v.name, "_abort_ready"}, cmd_ready, 1);
            end else begin
                chk({v.name, "_done"}, done, 1);
                chk({v.name, "_done_wen"}, wEn, 0);
                chk({v.name, "_done_ready"}, cmd_ready, 0);
                @(negedge clk);
                chk({v.name, "_ready_after"}, cmd_ready, 1);
                chk({v.name, "_done_low"}, done, 0);
            end
        end
        chk({v.name, "_writes"}, wrSeen, v.expWrites);
        chk({v.name, "_queue_left"}, expQ.size(), 0);
        expQ.delete();
    endtask

    // Global bound so the bench always terminates.
    initial begin
        #500000;
        compared++; mismatched++;
        $display("FAIL global_timeout: got no finish expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        bit  okIdle;
        wr_t e;

        //            name        x    y    w     h  color  outl abort hold exp
        vecs.push_back('{"basic",      10,   2,    3, 2,   5,  0, -1, 0,   6});
        vecs.push_back('{"clip",      638, 479,    5, 4,   7,  0, -1, 0,   2});
        vecs.push_back('{"emptyW",      5,   5,    0, 3,   1,  0, -1, 0,   0});
        vecs.push_back('{"emptyX",    700,   5,    4, 3,   1,  0, -1, 0,   0});
        vecs.push_back('{"emptyY",     10, 500,    4, 3,   1,  0, -1, 0,   0});
        vecs.push_back('{"emptyH",     10,  10,    4, 0,   1,  0, -1, 0,   0});
        vecs.push_back('{"abort",       0,   0,    4, 1,   3,  0,  2, 0,   3});
        vecs.push_back('{"afterAbort", 100, 100,   2, 2,   9,  0, -1, 0,   4});
        vecs.push_back('{"clipRight", 630,   0,   20, 3, 511,  0, -1, 0,  30});
        vecs.push_back('{"clipBottom",  0, 478,    2, 5,   4,  0, -1, 0,   4});
        vecs.push_back('{"fullRow",     0,   0, 1023, 1, 170,  0, -1, 0, 640});
        vecs.push_back('{"holdValid",  20,  20,    4, 2,   3,  0, -1, 1,   8});
        vecs.push_back('{"single",    639, 479,    1, 1, 256,  0, -1, 0,   1});
`ifdef FB_RECT_WRITER_OUTLINE_EN
        vecs.push_back('{"outline",     0,   0,    3, 3,   6,  1, -1, 0,   8});
        vecs.push_back('{"outlineClip",637,  0,    9, 4,   2,  1, -1, 0,  10});
`endif

        reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
`ifdef FB_RECT_WRITER_OUTLINE_EN
        cmd_outline = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_wen", wEn, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", dataIn, 0);

        okIdle = 1'b1;
        repeat (10) begin
            @(negedge clk);
            okIdle &= (wEn === 1'b0) && (cmd_ready === 1'b1) && (busy === 1'b0) && (done === 1'b0);
        end
        chk("idle_quiet", okIdle, 1);

        foreach (vecs[i]) runCmd(vecs[i]);

        // Reset in the middle of a long row: writes stop at that edge and no done follows.
        for (int c = 0; c < 20; c++) begin
            e.a = ADDR_W'(c);
            e.d = DATA_W'(77);
            expQ.push_back(e);
        end
        wrSeen    = 0;
        cmd_valid = 1'b1;
        cmd_x = '0; cmd_y = '0; cmd_w = 10'd20; cmd_h = 9'd1; cmd_color = DATA_W'(77);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_wen", wEn, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_ready", cmd_ready, 1);
        reset = 1'b0;
        okIdle = 1'b1;
        repeat (5) begin
            @(negedge clk);
            okIdle &= (wEn === 1'b0) && (done === 1'b0);
        end
        chk("rstmid_quiet", okIdle, 1);
        chk("rstmid_writes", wrSeen, 3);
        expQ.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
